rps_round_ctrl: RTL and testbench

Round sequencer for the rock-paper-scissors learning game. It latches the player's move and queries the move predictor for a forecast of that move. It then plays the counter-move, scores the round and sends the round's combination back to the predictor as a training update. It sits between the switch/key front end and the predictor. It owns scores, round count and the game-over condition.

---
 rtl/rps_pkg.sv | 41 ++++
 rtl/rps_round_ctrl_if.sv | 22 ++
 rtl/rps_score_unit.sv | 41 ++++
 rtl/rps_round_ctrl.sv | 138 +++++++++++++
 tb/tb_rps_round_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rps_pkg.sv
// Shared move/result encodings, round-controller state type and the game rules
// used by the round controller, predictor and display blocks.
package rps_pkg;

   localparam logic [1:0] ROCK     = 2'd0;
   localparam logic [1:0] PAPER    = 2'd1;
   localparam logic [1:0] SCISSORS = 2'd2;
   localparam logic [1:0] NONE     = 2'd3;

   localparam logic [1:0] DRAW   = 2'b00;
   localparam logic [1:0] P_WIN  = 2'b01;
   localparam logic [1:0] AI_WIN = 2'b10;
   localparam logic [1:0] R_NONE = 2'b11;

   typedef enum logic [2:0] {IDLE, QUERY, RESOLVE, UPDATE, OVER} state_e;

   // Move that defeats m; an invalid move maps to ROCK so callers never see NONE.
   function automatic logic [1:0] beat(input logic [1:0] m);
      logic [1:0] r;
      case (m)
         ROCK:     r = PAPER;
         PAPER:    r = SCISSORS;
         SCISSORS: r = ROCK;
         default:  r = ROCK;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] outcome(input logic [1:0] player, input logic [1:0] ai);
      logic [1:0] r;
      if (player == ai) begin
         r = DRAW;
      end else if (player == beat(ai)) begin
         r = P_WIN;
      end else begin
         r = AI_WIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/rps_round_ctrl_if.sv
// Request/response and training-update handshakes between the round
// controller (master) and the move predictor (slave).
interface rps_round_ctrl_if;

   logic       pred_req;
   logic       pred_valid;
   logic [1:0] pred_choice;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] upd_comb;

   modport master (
      output pred_req, upd_valid, upd_comb,
      input  pred_valid, pred_choice, upd_ready
   );

   modport slave (
      input  pred_req, upd_valid, upd_comb,
      output pred_valid, pred_choice, upd_ready
   );

endinterface

// File: rtl/rps_score_unit.sv
// Saturating per-side score counters, wrapping round counter and the
// win-target compare that ends the game.
module rps_score_unit
   import rps_pkg::*;
#(
   parameter int unsigned SCORE_W    = 4,
   parameter int unsigned WIN_TARGET = 5,
   parameter int unsigned ROUND_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               score_en,
   input  logic [1:0]         round_result,
   output logic [SCORE_W-1:0] score_player,
   output logic [SCORE_W-1:0] score_ai,
   output logic [ROUND_W-1:0] round_count,
   output logic               won
);

   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         score_player <= '0;
         score_ai     <= '0;
         round_count  <= '0;
      end else if (score_en) begin
         round_count <= round_count + 1'b1;
         if (round_result == P_WIN && score_player != '1) begin
            score_player <= score_player + 1'b1;
         end
         if (round_result == AI_WIN && score_ai != '1) begin
            score_ai <= score_ai + 1'b1;
         end
      end
   end

   assign won = (score_player >= TARGET) || (score_ai >= TARGET);

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: latch player move, query predictor, play the counter-move,
// score the round and hand the move combination back as a training update.
module rps_round_ctrl
   import rps_pkg::*;
#(
   parameter int unsigned SCORE_W    = 4,
   parameter int unsigned WIN_TARGET = 5,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned ROUND_W    = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  new_game,
   input  logic [1:0]            player_move,
   rps_round_ctrl_if.master      bus,
   output logic [1:0]            ai_move,
   output logic [1:0]            result,
   output logic [SCORE_W-1:0]    score_player,
   output logic [SCORE_W-1:0]    score_ai,
   output logic [ROUND_W-1:0]    round_count,
   output logic                  busy,
   output logic                  game_over,
   output logic                  err
);

   localparam int unsigned        TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   state_e             state;
   logic [1:0]         pmove;
   logic [1:0]         fb_cnt;
   logic [TIMER_W-1:0] timer;
   logic [1:0]         round_result;
   logic               score_en;
   logic               won;

   assign round_result = outcome(pmove, ai_move);
   assign score_en     = (state == RESOLVE) && !new_game;

   always_ff @(posedge clock) begin
      if (!reset) begin
         fb_cnt <= 2'd0;
      end else begin
         fb_cnt <= (fb_cnt == 2'd2) ? 2'd0 : fb_cnt + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         pmove         <= ROCK;
         timer         <= '0;
         ai_move       <= NONE;
         result        <= R_NONE;
         bus.pred_req  <= 1'b0;
         bus.upd_valid <= 1'b0;
         bus.upd_comb  <= '0;
         busy          <= 1'b0;
         game_over     <= 1'b0;
         err           <= 1'b0;
      end else if (new_game) begin
         // Aborts any round in flight; the pending update is never issued.
         state         <= IDLE;
         ai_move       <= NONE;
         result        <= R_NONE;
         bus.pred_req  <= 1'b0;
         bus.upd_valid <= 1'b0;
         busy          <= 1'b0;
         game_over     <= 1'b0;
         err           <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && player_move != NONE) begin
                  pmove        <= player_move;
                  timer        <= '0;
                  bus.pred_req <= 1'b1;
                  busy         <= 1'b1;
                  state        <= QUERY;
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            QUERY: begin
               if (bus.pred_valid || timer == TIMER_LAST) begin
                  // A malformed prediction is handled like a missing one.
                  ai_move      <= (bus.pred_valid && bus.pred_choice != NONE) ?
                                  beat(bus.pred_choice) : beat(fb_cnt);
                  bus.pred_req <= 1'b0;
                  state        <= RESOLVE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESOLVE: begin
               result        <= round_result;
               bus.upd_comb  <= {ai_move, pmove};
               bus.upd_valid <= 1'b1;
               state         <= UPDATE;
            end
            UPDATE: begin
               if (bus.upd_ready) begin
                  bus.upd_valid <= 1'b0;
                  busy          <= 1'b0;
                  if (won) begin
                     game_over <= 1'b1;
                     state     <= OVER;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OVER: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

   rps_score_unit #(
      .SCORE_W    (SCORE_W),
      .WIN_TARGET (WIN_TARGET),
      .ROUND_W    (ROUND_W)
   ) u_score (
      .clock        (clock),
      .reset        (reset),
      .clear        (new_game),
      .score_en     (score_en),
      .round_result (round_result),
      .score_player (score_player),
      .score_ai     (score_ai),
      .round_count  (round_count),
      .won          (won)
   );

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl with a scoreboard of expected round outcomes.
module tb_rps_round_ctrl;

   localparam int unsigned SCORE_W    = 4;
   localparam int unsigned WIN_TARGET = 5;
   localparam int unsigned TIMEOUT    = 15;
   localparam int unsigned ROUND_W    = 8;

   typedef struct {
      logic [1:0] ai;
      logic [1:0] res;
      logic [3:0] comb;
   } exp_t;

   logic               clock;
   logic               reset;
   logic               start;
   logic               new_game;
   logic [1:0]         player_move;
   logic [1:0]         ai_move;
   logic [1:0]         result;
   logic [SCORE_W-1:0] score_player;
   logic [SCORE_W-1:0] score_ai;
   logic [ROUND_W-1:0] round_count;
   logic               busy;
   logic               game_over;
   logic               err;
   logic [1:0]         fb_model;

   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t cur;

   rps_round_ctrl_if bus ();

   rps_round_ctrl #(
      .SCORE_W    (SCORE_W),
      .WIN_TARGET (WIN_TARGET),
      .TIMEOUT    (TIMEOUT),
      .ROUND_W    (ROUND_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .new_game     (new_game),
      .player_move  (player_move),
      .bus          (bus),
      .ai_move      (ai_move),
      .result       (result),
      .score_player (score_player),
      .score_ai     (score_ai),
      .round_count  (round_count),
      .busy         (busy),
      .game_over    (game_over),
      .err          (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference for the free-running mod-3 fallback counter.
   always @(posedge clock) begin
      if (!reset) fb_model <= 2'd0;
      else fb_model <= (fb_model == 2'd2) ? 2'd0 : fb_model + 2'd1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] m_counter(input int pc);
      return 2'((pc + 1) % 3);
   endfunction

   function automatic logic [1:0] m_result(input int pm, input int ai);
      if (pm == ai) return 2'b00;
      if (pm == (ai + 1) % 3) return 2'b01;
      return 2'b10;
   endfunction

   task automatic push_exp(input int pm, input logic [1:0] ai);
      exp_t e;
      e.ai   = ai;
      e.res  = m_result(pm, int'(ai));
      e.comb = {ai, 2'(pm)};
      sb.push_back(e);
   endtask

   task automatic wait_update();
      int n = 0;
      while (!bus.upd_valid && n < 40) begin
         tick();
         n++;
      end
      check("upd_valid_seen", bus.upd_valid, 1);
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         check("upd_comb", bus.upd_comb, cur.comb);
         check("ai_move", ai_move, cur.ai);
         check("result", result, cur.res);
      end
   endtask

   task automatic play_round(input int pm, input int pc, input int stall);
      push_exp(pm, m_counter(pc));
      player_move = 2'(pm);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("pred_req_up", bus.pred_req, 1);
      bus.pred_valid  = 1'b1;
      bus.pred_choice = 2'(pc);
      tick();
      bus.pred_valid = 1'b0;
      check("pred_req_drop", bus.pred_req, 0);
      wait_update();
      for (int i = 0; i < stall; i++) begin
         check("stall_valid", bus.upd_valid, 1);
         check("stall_comb", bus.upd_comb, cur.comb);
         check("stall_busy", busy, 1);
         tick();
      end
      bus.upd_ready = 1'b1;
      tick();
      bus.upd_ready = 1'b0;
      check("upd_valid_done", bus.upd_valid, 0);
      check("busy_done", busy, 0);
   endtask

   initial begin
      int n;
      logic [1:0] exp_ai;
      checks = 0;
      errors = 0;
      reset = 1'b0;
      start = 1'b0;
      new_game = 1'b0;
      player_move = 2'd0;
      bus.pred_valid = 1'b0;
      bus.pred_choice = 2'd0;
      bus.upd_ready = 1'b0;
      repeat (3) tick();

      check("rst_ai_move", ai_move, 3);
      check("rst_result", result, 3);
      check("rst_score_p", score_player, 0);
      check("rst_score_ai", score_ai, 0);
      check("rst_rounds", round_count, 0);
      check("rst_pred_req", bus.pred_req, 0);
      check("rst_upd_valid", bus.upd_valid, 0);
      check("rst_upd_comb", bus.upd_comb, 0);
      check("rst_busy_over_err", {busy, game_over, err}, 0);
      reset = 1'b1;
      tick();

      // Rock against a rock prediction: AI plays paper and wins.
      play_round(0, 0, 0);
      check("r1_score_ai", score_ai, 1);
      check("r1_rounds", round_count, 1);

      // Predictor silent: fallback move after exactly TIMEOUT request cycles.
      n = 0;
      while (fb_model != 2'd2 && n < 5) begin
         tick();
         n++;
      end
      exp_ai = 2'((int'(fb_model) + TIMEOUT + 1) % 3);
      push_exp(1, exp_ai);
      player_move = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (bus.pred_req && n < 100) begin
         n++;
         tick();
      end
      check("timeout_req_cycles", n, TIMEOUT);
      wait_update();
      check("timeout_ai_rock", ai_move, 0);
      bus.upd_ready = 1'b1;
      tick();
      bus.upd_ready = 1'b0;
      check("timeout_score_p", score_player, 1);

      // Update back-pressure for 5 cycles.
      play_round(2, 2, 5);
      check("stall_score_ai", score_ai, 2);

      // Invalid move: one-cycle err, no request.
      player_move = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("err_pulse", err, 1);
      check("err_no_req", bus.pred_req, 0);
      tick();
      check("err_clear", err, 0);

      // Second start during QUERY must not re-latch the move.
      push_exp(0, m_counter(1));
      player_move = 2'd0;
      start = 1'b1;
      tick();
      player_move = 2'd1;
      tick();
      start = 1'b0;
      check("query_req_held", bus.pred_req, 1);
      bus.pred_valid = 1'b1;
      bus.pred_choice = 2'd1;
      tick();
      bus.pred_valid = 1'b0;
      wait_update();
      bus.upd_ready = 1'b1;
      tick();
      bus.upd_ready = 1'b0;
      check("query_score_p", score_player, 2);

      // new_game while the update is pending.
      push_exp(1, m_counter(1));
      player_move = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.pred_valid = 1'b1;
      bus.pred_choice = 2'd1;
      tick();
      bus.pred_valid = 1'b0;
      wait_update();
      tick();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check("ng_upd_valid", bus.upd_valid, 0);
      check("ng_scores", {score_player, score_ai}, 0);
      check("ng_rounds", round_count, 0);
      check("ng_result", result, 3);
      check("ng_ai_move", ai_move, 3);
      check("ng_busy", busy, 0);

      // reset mid-QUERY abandons the request.
      player_move = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rq_req_up", bus.pred_req, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rq_req_drop", bus.pred_req, 0);
      check("rq_busy", busy, 0);
      check("rq_result", result, 3);
      tick();

      // Player wins WIN_TARGET rounds in a row.
      for (int i = 0; i < int'(WIN_TARGET); i++) begin
         play_round(1, 2, 0);
         check("win_game_over", game_over, (i == int'(WIN_TARGET) - 1) ? 1 : 0);
      end
      check("win_score_p", score_player, WIN_TARGET);
      check("win_rounds", round_count, WIN_TARGET);
      player_move = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("over_no_req", bus.pred_req, 0);
      check("over_no_err", err, 0);
      check("over_held", game_over, 1);

      // new_game beats a simultaneous start.
      new_game = 1'b1;
      start = 1'b1;
      tick();
      new_game = 1'b0;
      start = 1'b0;
      check("ng_game_over", game_over, 0);
      check("ng_score_p2", score_player, 0);
      check("ng_start_drop", {busy, bus.pred_req}, 0);
      tick();
      check("ng_idle_stays", bus.pred_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
